// File: rtl/ifq_if.sv
// ifq_if: fetch-side bus bundle for the instruction fetch queue.
// Carries the icache request/response and the dispatch read/redirect signals.
// master = the fetch queue itself, slave = cache/dispatch environment.
interface ifq_if;
  logic         icache_rd_en;
  logic [31:0]  icache_addr;
  logic [127:0] icache_dout;
  logic         icache_dout_valid;
  logic [31:0]  ifq_inst;
  logic [31:0]  ifq_pc_out;
  logic         ifq_empty;
  logic         ifq_rd_en;
  logic [31:0]  ifq_jump_branch_address;
  logic         ifq_jump_branch_valid;

  modport master (
    output icache_rd_en, icache_addr, ifq_inst, ifq_pc_out, ifq_empty,
    input  icache_dout, icache_dout_valid, ifq_rd_en,
           ifq_jump_branch_address, ifq_jump_branch_valid
  );

  modport slave (
    input  icache_rd_en, icache_addr, ifq_inst, ifq_pc_out, ifq_empty,
    output icache_dout, icache_dout_valid, ifq_rd_en,
           ifq_jump_branch_address, ifq_jump_branch_valid
  );
endinterface

// File: rtl/ifq.sv
// ifq: instruction fetch queue. Fetches 128-bit lines from the icache,
// buffers up to DEPTH lines and hands one 32-bit instruction per cycle to
// dispatch. Dispatch can redirect fetch with a one-cycle jump/branch strobe.
// Optional build macro IFQ_POP_REFILL_EN: a full queue whose head line is
// popping this cycle may accept a new line in the same cycle.
module ifq #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic  clk,
  input logic  rst,
  ifq_if.master bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  // fetch PC kept as its line number; the low nibble is always zero
  logic [27:0]   fetch_line;
  logic [127:0]  line_data [DEPTH];
  logic [27:0]   line_tag  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    rd_off;

  logic full;
  logic empty;
  logic wr;
  logic rd;
  logic pop;

  // request / write / read qualification
  always_comb begin
    empty = (count == '0);
`ifdef IFQ_POP_REFILL_EN
    full  = (count == FULL_CNT) && !(bus.ifq_rd_en && rd_off == 2'd3);
`else
    full  = (count == FULL_CNT);
`endif
    bus.icache_rd_en = rst && !full && !bus.ifq_jump_branch_valid;
    wr  = bus.icache_rd_en && bus.icache_dout_valid;
    rd  = bus.ifq_rd_en && !empty;
    pop = rd && (rd_off == 2'd3);
  end

  assign bus.icache_addr = {fetch_line, 4'b0000};

  // head instruction presentation; forced to the idle values during reset
  always_comb begin
    if (!rst || empty) begin
      bus.ifq_empty  = 1'b1;
      bus.ifq_inst   = 32'h0;
      bus.ifq_pc_out = 32'h0;
    end else begin
      bus.ifq_empty  = 1'b0;
      bus.ifq_inst   = line_data[rd_ptr][{rd_off, 5'b00000} +: 32];
      bus.ifq_pc_out = {line_tag[rd_ptr], rd_off, 2'b00} + 32'd4;
    end
  end

  // queue state: reset, then redirect, then normal write/read
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_line <= RESET_PC[31:4];
      rd_off     <= RESET_PC[3:2];
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        line_data[i] <= '0;
        line_tag[i]  <= '0;
      end
    end else if (bus.ifq_jump_branch_valid) begin
      // the first line fetched after a redirect is entered at the target word
      fetch_line <= bus.ifq_jump_branch_address[31:4];
      rd_off     <= bus.ifq_jump_branch_address[3:2];
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (wr) begin
        line_data[wr_ptr] <= bus.icache_dout;
        line_tag[wr_ptr]  <= fetch_line;
        wr_ptr            <= wr_ptr + 1'b1;
        fetch_line        <= fetch_line + 28'd1;
      end
      if (rd) begin
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          rd_off <= 2'd0;
        end else begin
          rd_off <= rd_off + 2'd1;
        end
      end
      if (wr && !pop)
        count <= count + 1'b1;
      else if (pop && !wr)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_ifq.sv
// tb_ifq: directed bench for ifq with a line-queue reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_ifq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hit;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ifq_if bus();

  ifq #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef IFQ_POP_REFILL_EN
  localparam bit POP_REFILL = 1'b1;
`else
  localparam bit POP_REFILL = 1'b0;
`endif

  // cache image: every word holds its own address divided by 4
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = {2'b00, a[31:4], 2'b00};
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  assign bus.icache_dout       = line_of(bus.icache_addr);
  assign bus.icache_dout_valid = hit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of lines + head word ----------
  typedef struct packed {
    logic [27:0]  tag;
    logic [127:0] data;
  } mline_t;

  mline_t      mq[$];
  logic [31:0] mfpc;
  logic [1:0]  moff;
  bit          started = 1'b0;

  function automatic bit m_full();
    bit f;
    f = (mq.size() == 4);
`ifdef IFQ_POP_REFILL_EN
    f = f && !(bus.ifq_rd_en && moff == 2'd3);
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    bit w;
    bit r;
    started = 1'b1;
    if (!rst) begin
      mq.delete();
      mfpc = 32'h0;
      moff = 2'd0;
    end else if (bus.ifq_jump_branch_valid) begin
      mq.delete();
      mfpc = {bus.ifq_jump_branch_address[31:4], 4'b0000};
      moff = bus.ifq_jump_branch_address[3:2];
    end else begin
      w = !m_full() && hit;
      r = bus.ifq_rd_en && (mq.size() != 0);
      if (r) begin
        if (moff == 2'd3) begin
          void'(mq.pop_front());
          moff = 2'd0;
        end else begin
          moff = moff + 2'd1;
        end
      end
      if (w) begin
        mq.push_back({mfpc[31:4], line_of(mfpc)});
        mfpc = {mfpc[31:4] + 28'd1, 4'b0000};
      end
    end
  end

  always @(negedge clk) begin
    logic        e_rd;
    logic        e_empty;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    if (started) begin
      e_rd    = rst && !m_full() && !bus.ifq_jump_branch_valid;
      e_empty = !rst || (mq.size() == 0);
      e_inst  = 32'h0;
      e_pc    = 32'h0;
      if (!e_empty) begin
        e_inst = mq[0].data[int'(moff)*32 +: 32];
        e_pc   = {mq[0].tag, moff, 2'b00} + 32'd4;
      end
      chk("m_icache_rd_en", {31'b0, bus.icache_rd_en}, {31'b0, e_rd});
      chk("m_icache_addr", bus.icache_addr, {mfpc[31:4], 4'b0000});
      chk("m_ifq_empty", {31'b0, bus.ifq_empty}, {31'b0, e_empty});
      chk("m_ifq_inst", bus.ifq_inst, e_inst);
      chk("m_ifq_pc_out", bus.ifq_pc_out, e_pc);
    end
  end

  // ---------------- directed stimulus ------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins [16];
    logic [31:0] pcs [16];
    int n;

    hit = 1'b1;
    bus.ifq_rd_en = 1'b0;
    bus.ifq_jump_branch_valid = 1'b0;
    bus.ifq_jump_branch_address = 32'h0;

    // reset state
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", {31'b0, bus.ifq_empty}, 32'd1);
    chk("rst_inst", bus.ifq_inst, 32'h0);
    chk("rst_pc", bus.ifq_pc_out, 32'h0);
    chk("rst_rd_en", {31'b0, bus.icache_rd_en}, 32'd0);
    tick();

    // 1: streaming with hits, dispatch always reading
    bus.ifq_rd_en = 1'b1;
    do_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.ifq_empty && n < 16) begin
        ins[n] = bus.ifq_inst;
        pcs[n] = bus.ifq_pc_out;
        n++;
      end
      tick();
    end
    chk("t1_count", n, 32'd9);
    for (int i = 0; i < 8; i++) begin
      chk("t1_inst", ins[i], i);
      chk("t1_pc", pcs[i], 4*i + 4);
    end

    // 2: no reads, queue fills after exactly four requests
    bus.ifq_rd_en = 1'b0;
    do_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.icache_rd_en && n < 16) begin
        ins[n] = bus.icache_addr;
        n++;
      end
      tick();
    end
    chk("t2_requests", n, 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_addr", ins[i], 16*i);
    @(negedge clk);
    chk("t2_empty", {31'b0, bus.ifq_empty}, 32'd0);
    chk("t2_rd_en", {31'b0, bus.icache_rd_en}, 32'd0);
    tick();

    // 3: redirect to 0x1008 with three lines queued
    do_reset();
    tick(); tick(); tick();
    bus.ifq_jump_branch_valid = 1'b1;
    bus.ifq_jump_branch_address = 32'h0000_1008;
    @(negedge clk);
    chk("t3_strobe_rd_en", {31'b0, bus.icache_rd_en}, 32'd0);
    tick();
    bus.ifq_jump_branch_valid = 1'b0;
    @(negedge clk);
    chk("t3_addr", bus.icache_addr, 32'h0000_1000);
    chk("t3_empty", {31'b0, bus.ifq_empty}, 32'd1);
    tick();
    bus.ifq_rd_en = 1'b1;
    @(negedge clk);
    chk("t3_inst0", bus.ifq_inst, 32'h0000_0402);
    chk("t3_pc0", bus.ifq_pc_out, 32'h0000_100C);
    tick();
    @(negedge clk);
    chk("t3_inst1", bus.ifq_inst, 32'h0000_0403);
    chk("t3_pc1", bus.ifq_pc_out, 32'h0000_1010);
    tick();
    @(negedge clk);
    chk("t3_inst2", bus.ifq_inst, 32'h0000_0404);
    chk("t3_pc2", bus.ifq_pc_out, 32'h0000_1014);
    tick();
    bus.ifq_rd_en = 1'b0;

    // 4: cache misses right after reset
    hit = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_addr", bus.icache_addr, 32'h0);
      chk("t4_empty", {31'b0, bus.ifq_empty}, 32'd1);
      tick();
    end
    hit = 1'b1;
    @(negedge clk);
    chk("t4_addr_hit", bus.icache_addr, 32'h0);
    tick();
    @(negedge clk);
    chk("t4_empty_after", {31'b0, bus.ifq_empty}, 32'd0);
    chk("t4_inst", bus.ifq_inst, 32'h0);

    // 5: reset mid-stream with two lines queued
    tick();
    do_reset();
    tick(); tick();
    hit = 1'b0;
    @(negedge clk);
    chk("t5_pre_empty", {31'b0, bus.ifq_empty}, 32'd0);
    chk("t5_pre_addr", bus.icache_addr, 32'h20);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_empty", {31'b0, bus.ifq_empty}, 32'd1);
    chk("t5_inst", bus.ifq_inst, 32'h0);
    chk("t5_pc", bus.ifq_pc_out, 32'h0);
    chk("t5_rd_en", {31'b0, bus.icache_rd_en}, 32'd0);
    tick();
    rst = 1'b1;
    hit = 1'b1;
    @(negedge clk);
    chk("t5_restart_addr", bus.icache_addr, 32'h0);
    chk("t5_restart_rd_en", {31'b0, bus.icache_rd_en}, 32'd1);
    tick();

    // 6: full queue popping its head line while the cache hits
    do_reset();
    tick(); tick(); tick(); tick();
    bus.ifq_rd_en = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t6_inst_w3", bus.ifq_inst, 32'd3);
    chk("t6_pop_rd_en", {31'b0, bus.icache_rd_en}, POP_REFILL ? 32'd1 : 32'd0);
    tick();
    bus.ifq_rd_en = 1'b0;
    @(negedge clk);
    chk("t6_next_rd_en", {31'b0, bus.icache_rd_en}, POP_REFILL ? 32'd0 : 32'd1);
    chk("t6_next_inst", bus.ifq_inst, 32'd4);
    chk("t6_next_pc", bus.ifq_pc_out, 32'h14);
    tick();

    // 7: redirect to the top line, fetch PC wraps to zero
    bus.ifq_jump_branch_valid = 1'b1;
    bus.ifq_jump_branch_address = 32'hFFFF_FFFE;
    tick();
    bus.ifq_jump_branch_valid = 1'b0;
    @(negedge clk);
    chk("t7_addr", bus.icache_addr, 32'hFFFF_FFF0);
    tick();
    @(negedge clk);
    chk("t7_inst", bus.ifq_inst, 32'h3FFF_FFFF);
    chk("t7_pc", bus.ifq_pc_out, 32'h0);
    chk("t7_wrap_addr", bus.icache_addr, 32'h0);
    chk("t7_empty", {31'b0, bus.ifq_empty}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifq.md
# ifq

Instruction fetch queue: the producer end of the fetch/dispatch interface. It owns the fetch PC and reads 128-bit lines (four instructions) from the instruction cache. It buffers up to `DEPTH` lines and presents one instruction per cycle to dispatch through `ifq_inst` / `ifq_pc_out` / `ifq_empty` / `ifq_rd_en`. It also accepts the jump/branch redirect that dispatch drives back.

## Interface
- `DEPTH`, 4: number of 128-bit line entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `icache_rd_en` out 1: line read request (combinational).
- `icache_addr` out 32: line address `{fetch_pc[31:4], 4'b0}`.
- `icache_dout` in 128: returned line; word k at bits `[32k+31:32k]`.
- `icache_dout_valid` in 1: same-cycle hit for the current request; low means miss, so retry next cycle.
- `ifq_inst` out 32: instruction at queue head.
- `ifq_pc_out` out 32: head instruction address + 4.
- `ifq_empty` out 1: no instruction available.
- `ifq_rd_en` in 1: dispatch consumes head instruction this cycle.
- `ifq_jump_branch_address` in 32: redirect target; bits `[1:0]` ignored.
- `ifq_jump_branch_valid` in 1: redirect strobe, one cycle.

## Operation
- **State:**
  - `fetch_pc` (32).
  - Line storage: `DEPTH` × (128-bit data + 28-bit line tag).
  - `wr_ptr` and `rd_ptr`, log2(`DEPTH`) bits each, wrapping modulo `DEPTH`.
  - `count`, 0..`DEPTH`.
  - Head word offset `rd_off` (2 bits).
- **Request:** `icache_rd_en = rst & !full & !ifq_jump_branch_valid`, where `full = (count == DEPTH)`.
- **Write:** `icache_rd_en & icache_dout_valid` performs the write:
  - Store the line and `fetch_pc[31:4]` at `wr_ptr`.
  - `wr_ptr++`.
  - `fetch_pc <= {fetch_pc[31:4] + 1, 4'b0}`; 28-bit wrap from 0xFFFF_FFF0 to 0.
- **Read:** `ifq_rd_en & !ifq_empty` performs the read:
  - `rd_off++`.
  - At `rd_off == 3` the head line is popped: `rd_ptr++`, `rd_off <= 0`.
  - `ifq_rd_en` while empty is ignored.
- **count:** +1 on write only, −1 on pop only, unchanged when both happen.
- **Outputs:**
  - `ifq_empty = (count == 0)`.
  - When not empty: `ifq_inst = word rd_off of line rd_ptr`, and `ifq_pc_out = {tag, rd_off, 2'b00} + 4`.
  - When empty: both are 0.
- **Redirect** (`ifq_jump_branch_valid == 1`, highest priority):
  - `count <= 0`, `wr_ptr <= 0`, `rd_ptr <= 0`.
  - `rd_off <= target[3:2]`.
  - `fetch_pc <= {target[31:4], 4'b0}`.
  - Any read or cache data in that cycle is discarded.
  - The first line written afterwards is consumed starting at word `target[3:2]`.
- **Reset** (`rst == 0` at edge), from any state including mid-refill:
  - `fetch_pc <= RESET_PC` aligned to its line; `rd_off <= RESET_PC[3:2]`.
  - Pointers and `count` go to 0; line storage is cleared to 0.
  - Output values: `ifq_empty = 1`, `ifq_inst = 0`, `ifq_pc_out = 0`, `icache_rd_en = 0` while `rst` is low.

## Timing
- Fetch latency: a line written at edge N is visible on `ifq_inst` / `ifq_empty = 0` after edge N. There is no same-cycle bypass from the cache to the outputs.
- Throughput: one line per cycle in and one instruction per cycle out. With cache hits, a 4-deep queue never starves dispatch.
- Redirect: strobe at edge N, then `icache_addr = target line` in cycle N+1, then the first instruction is presented after edge N+1 if the cache hits.
- Full boundary: with `count == DEPTH`, `icache_rd_en = 0` even if the head line pops this cycle; the refill happens the next cycle (see Configuration).
- Empty boundary: a write and an `ifq_rd_en` in the same cycle while empty leaves the read ignored and `count` = 1.

## Configuration
- `IFQ_POP_REFILL_EN` defined: `full` is computed as `count == DEPTH & !(ifq_rd_en & rd_off == 3)`. A full queue whose head line is popping may accept a new line in the same cycle, and `count` stays at `DEPTH`.
- Undefined: `full = (count == DEPTH)`, with a one-cycle refill bubble as stated in Timing.

## Test plan
- Reset release with `RESET_PC = 0`, cache always hits with line n = {4n+3, 4n+2, 4n+1, 4n}, `ifq_rd_en = 1` → `ifq_inst` = 0,1,2,… on consecutive cycles, `ifq_pc_out` = 4,8,12,…
- Reset release, `ifq_rd_en = 0` for 10 cycles → exactly 4 `icache_rd_en` cycles (addresses 0x00, 0x10, 0x20, 0x30), then `icache_rd_en = 0` and `ifq_empty = 0`.
- Redirect to 0x0000_1008 while the queue holds 3 lines → next `icache_addr` = 0x1000; first `ifq_inst` = word 2, with `ifq_pc_out` = 0x100C; all old instructions are dropped.
- `icache_dout_valid = 0` for 5 cycles from reset → `icache_addr` is held at 0x0, `ifq_empty` stays 1, `fetch_pc` is not advanced.
- Assert `rst = 0` mid-stream with `count = 2` → the next cycle shows `ifq_empty = 1`, `ifq_inst = 0`, `ifq_pc_out = 0`, `icache_rd_en = 0`. After release, fetch restarts at `RESET_PC`.
- Full queue, pop of the head's word 3 in the same cycle as a cache hit → with `IFQ_POP_REFILL_EN`, `icache_rd_en = 1` and `count` stays 4; without it, `icache_rd_en = 0` and `count` becomes 3.
